// File: rtl/uart_tx_if.sv
// Byte-stream handshake and serial outputs of the uart_tx transmitter.
// The transmitter drives the o_* signals; its byte source drives the i_* signals.
interface uart_tx_if;
  logic       i_Tx_Valid;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Ready;
  logic       o_Tx_UART;
  logic       o_Tx_Active;
  logic       o_Tx_Completed;

  modport master (
    output i_Tx_Valid, i_Tx_Byte,
    input  o_Tx_Ready, o_Tx_UART, o_Tx_Active, o_Tx_Completed
  );

  modport slave (
    input  i_Tx_Valid, i_Tx_Byte,
    output o_Tx_Ready, o_Tx_UART, o_Tx_Active, o_Tx_Completed
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register, so back-to-back
// frames leave the line with no idle gap between them.
module uart_tx #(
  parameter int unsigned p_CLKs_PB = 217
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Tx_Valid,
  input  logic [7:0] i_Tx_Byte,
  output logic       o_Tx_Ready,
  output logic       o_Tx_UART,
  output logic       o_Tx_Active,
  output logic       o_Tx_Completed
);

  localparam int unsigned           c_CNT_W = $clog2(p_CLKs_PB);
  localparam logic [c_CNT_W-1:0]    c_LAST  = c_CNT_W'(p_CLKs_PB - 1);
  localparam logic [c_CNT_W-1:0]    c_PRE   = c_CNT_W'(p_CLKs_PB - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             r_State;
  logic [c_CNT_W-1:0] r_Count;
  logic [2:0]         r_Bit_Idx;
  logic [7:0]         r_Shift;
  logic [7:0]         r_Hold;
  logic               r_Hold_Full;
  logic               w_Accept;
  logic               w_Bit_End;

  assign o_Tx_Ready = ~r_Hold_Full;
  assign w_Accept   = i_Tx_Valid & ~r_Hold_Full;
  assign w_Bit_End  = (r_Count == c_LAST);

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values; the data registers are reset too since they are tiny.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State        <= IDLE;
      r_Count        <= '0;
      r_Bit_Idx      <= '0;
      r_Shift        <= '0;
      r_Hold         <= '0;
      r_Hold_Full    <= 1'b0;
      o_Tx_UART      <= 1'b1;
      o_Tx_Active    <= 1'b0;
      o_Tx_Completed <= 1'b0;
    end else begin
      o_Tx_Completed <= 1'b0;

      // Acceptance needs an empty holding register and a load needs a full
      // one, so the two never collide on the same edge.
      if (w_Accept) begin
        r_Hold      <= i_Tx_Byte;
        r_Hold_Full <= 1'b1;
      end

      case (r_State)
        IDLE: begin
          if (r_Hold_Full) begin
            r_State     <= START;
            r_Shift     <= r_Hold;
            r_Hold_Full <= 1'b0;
            r_Count     <= '0;
            o_Tx_UART   <= 1'b0;
            o_Tx_Active <= 1'b1;
          end
        end

        START: begin
          if (w_Bit_End) begin
            r_State   <= DATA;
            r_Count   <= '0;
            r_Bit_Idx <= '0;
            o_Tx_UART <= r_Shift[0];
          end else begin
            r_Count <= r_Count + c_CNT_W'(1);
          end
        end

        DATA: begin
          if (w_Bit_End) begin
            r_Count <= '0;
            if (r_Bit_Idx == 3'd7) begin
              r_State   <= STOP;
              o_Tx_UART <= 1'b1;
            end else begin
              r_Bit_Idx <= r_Bit_Idx + 3'd1;
              r_Shift   <= r_Shift >> 1;
              o_Tx_UART <= r_Shift[1];
            end
          end else begin
            r_Count <= r_Count + c_CNT_W'(1);
          end
        end

        STOP: begin
          if (w_Bit_End) begin
            r_Count <= '0;
            if (r_Hold_Full) begin
              r_State     <= START;
              r_Shift     <= r_Hold;
              r_Hold_Full <= 1'b0;
              o_Tx_UART   <= 1'b0;
            end else begin
              r_State     <= IDLE;
              o_Tx_Active <= 1'b0;
            end
          end else begin
            r_Count <= r_Count + c_CNT_W'(1);
            // Registered pulse lands exactly on the final stop-bit cycle.
            if (r_Count == c_PRE) o_Tx_Completed <= 1'b1;
          end
        end

        default: r_State <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven single frames at 4 clocks/bit,
// plus hand-written back-to-back, reset-abort, 2 clocks/bit and 217 clocks/bit cases.
module tb_uart_tx;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  longint t_comp;

  uart_tx_if bus4 ();
  uart_tx_if bus2 ();
  uart_tx_if bus217 ();

  uart_tx #(.p_CLKs_PB(4)) u_dut4 (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_Tx_Valid(bus4.i_Tx_Valid), .i_Tx_Byte(bus4.i_Tx_Byte),
    .o_Tx_Ready(bus4.o_Tx_Ready), .o_Tx_UART(bus4.o_Tx_UART),
    .o_Tx_Active(bus4.o_Tx_Active), .o_Tx_Completed(bus4.o_Tx_Completed)
  );

  uart_tx #(.p_CLKs_PB(2)) u_dut2 (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_Tx_Valid(bus2.i_Tx_Valid), .i_Tx_Byte(bus2.i_Tx_Byte),
    .o_Tx_Ready(bus2.o_Tx_Ready), .o_Tx_UART(bus2.o_Tx_UART),
    .o_Tx_Active(bus2.o_Tx_Active), .o_Tx_Completed(bus2.o_Tx_Completed)
  );

  uart_tx #(.p_CLKs_PB(217)) u_dut217 (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_Tx_Valid(bus217.i_Tx_Valid), .i_Tx_Byte(bus217.i_Tx_Byte),
    .o_Tx_Ready(bus217.o_Tx_Ready), .o_Tx_UART(bus217.o_Tx_UART),
    .o_Tx_Active(bus217.o_Tx_Active), .o_Tx_Completed(bus217.o_Tx_Completed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [9:0] frame;  // bit n = line level during bit period n
  } vec_t;

  vec_t vecs [6];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send4(logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (bus4.o_Tx_Ready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_send", 32'(bus4.o_Tx_Ready), 32'd1);
    bus4.i_Tx_Valid = 1'b1;
    bus4.i_Tx_Byte  = b;
    @(posedge clk);
    #1;
    bus4.i_Tx_Valid = 1'b0;
    check("ready_drop_after_accept", 32'(bus4.o_Tx_Ready), 32'd0);
  endtask

  // Returns number of falling clock edges sampled until the line reads low.
  task automatic wait_fall4(output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus4.o_Tx_UART !== 1'b0 && waited < 500);
    if (waited >= 500) check("wait_fall_timeout", 32'(waited), 32'd0);
  endtask

  // Called on the first sample after the line falls (cycle 0 of the frame).
  task automatic check_frame4(string name, logic [9:0] exp);
    logic [9:0] obs;
    int off_cycles, comp_cnt, comp_idx, inactive;
    obs = '0; off_cycles = 0; comp_cnt = 0; comp_idx = -1; inactive = 0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clk);
      if (n % 4 == 2) obs[n/4] = bus4.o_Tx_UART;
      if (bus4.o_Tx_UART !== exp[n/4]) off_cycles++;
      if (bus4.o_Tx_Active !== 1'b1) inactive++;
      if (bus4.o_Tx_Completed === 1'b1) begin
        comp_cnt++;
        comp_idx = n;
        t_comp = $time;
      end
    end
    check({name, "_frame"}, 32'(obs), 32'(exp));
    check({name, "_cycles_off"}, 32'(off_cycles), 32'd0);
    check({name, "_inactive"}, 32'(inactive), 32'd0);
    check({name, "_done_count"}, 32'(comp_cnt), 32'd1);
    check({name, "_done_cycle"}, 32'(comp_idx), 32'd39);
  endtask

  initial begin
    int w, lows, first_high, comp_at, low_cnt, comp_cnt;
    longint t_first;
    logic [9:0] rx;

    vecs[0] = '{"b37", 8'h37, 10'h26E};
    vecs[1] = '{"bA5", 8'hA5, 10'h34A};
    vecs[2] = '{"b3C", 8'h3C, 10'h278};
    vecs[3] = '{"b00", 8'h00, 10'h200};
    vecs[4] = '{"bFF", 8'hFF, 10'h3FE};
    vecs[5] = '{"b55", 8'h55, 10'h2AA};

    bus4.i_Tx_Valid = 1'b0;   bus4.i_Tx_Byte = 8'h00;
    bus2.i_Tx_Valid = 1'b0;   bus2.i_Tx_Byte = 8'h00;
    bus217.i_Tx_Valid = 1'b0; bus217.i_Tx_Byte = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(bus4.o_Tx_Ready), 32'd1);
    check("rst_uart", 32'(bus4.o_Tx_UART), 32'd1);
    check("rst_active", 32'(bus4.o_Tx_Active), 32'd0);
    check("rst_done", 32'(bus4.o_Tx_Completed), 32'd0);
    check("rst_uart_p2", 32'(bus2.o_Tx_UART), 32'd1);
    check("rst_ready_p217", 32'(bus217.o_Tx_Ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_uart", 32'(bus4.o_Tx_UART), 32'd1);

    // Single frames from the table.
    for (int i = 0; i < 6; i++) begin
      send4(vecs[i].data);
      wait_fall4(w);
      check({vecs[i].name, "_latency"}, 32'(w), 32'd2);
      check_frame4(vecs[i].name, vecs[i].frame);
    end

    // Back-to-back A5 then 3C, with a held valid and changing byte afterwards.
    send4(8'hA5);
    wait_fall4(w);
    check("b2b_latency", 32'(w), 32'd2);
    fork
      check_frame4("b2b_first", 10'h34A);
      begin
        repeat (2) @(negedge clk);
        check("ready_in_flight", 32'(bus4.o_Tx_Ready), 32'd1);
        bus4.i_Tx_Valid = 1'b1;
        bus4.i_Tx_Byte  = 8'h3C;
        @(posedge clk);
        #1;
        bus4.i_Tx_Byte = 8'hFF;
        check("ready_low_queued", 32'(bus4.o_Tx_Ready), 32'd0);
        repeat (10) @(negedge clk);
        bus4.i_Tx_Byte = 8'h00;
        repeat (10) @(negedge clk);
        bus4.i_Tx_Valid = 1'b0;
      end
    join
    t_first = t_comp;
    wait_fall4(w);
    check("b2b_no_gap", 32'(w), 32'd1);
    check_frame4("b2b_second", 10'h278);
    check("b2b_done_spacing", 32'(t_comp - t_first), 32'd400);
    lows = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus4.o_Tx_UART !== 1'b1) lows++;
    end
    check("no_extra_frame", 32'(lows), 32'd0);

    // Reset during DATA bit 3 of a 0x00 frame (line low at that point).
    send4(8'h00);
    wait_fall4(w);
    repeat (17) @(negedge clk);
    check("pre_reset_line_low", 32'(bus4.o_Tx_UART), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_uart", 32'(bus4.o_Tx_UART), 32'd1);
    check("abort_active", 32'(bus4.o_Tx_Active), 32'd0);
    check("abort_ready", 32'(bus4.o_Tx_Ready), 32'd1);
    check("abort_done", 32'(bus4.o_Tx_Completed), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    comp_cnt = 0; lows = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus4.o_Tx_Completed === 1'b1) comp_cnt++;
      if (bus4.o_Tx_UART !== 1'b1) lows++;
    end
    check("abort_no_done", 32'(comp_cnt), 32'd0);
    check("abort_line_idle", 32'(lows), 32'd0);
    send4(8'h55);
    wait_fall4(w);
    check("post_reset_latency", 32'(w), 32'd2);
    check_frame4("post_reset_b55", 10'h2AA);

    // Two clocks per bit, byte 0x00: 18 low cycles then 2 high.
    @(negedge clk);
    bus2.i_Tx_Valid = 1'b1;
    bus2.i_Tx_Byte  = 8'h00;
    @(posedge clk);
    #1 bus2.i_Tx_Valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus2.o_Tx_UART !== 1'b0 && w < 50);
    check("p2_latency", 32'(w), 32'd2);
    low_cnt = 0; first_high = -1; comp_at = -1;
    for (int n = 0; n < 22; n++) begin
      if (n > 0) @(negedge clk);
      if (bus2.o_Tx_UART === 1'b0) low_cnt++;
      else if (first_high < 0) first_high = n;
      if (bus2.o_Tx_Completed === 1'b1) comp_at = n;
    end
    check("p2_low_cycles", 32'(low_cnt), 32'd18);
    check("p2_first_high", 32'(first_high), 32'd18);
    check("p2_done_cycle", 32'(comp_at), 32'd19);
    check("p2_idle_after", 32'(bus2.o_Tx_Active), 32'd0);

    // 217 clocks per bit: mid-bit sampling receiver must recover 0x37.
    @(negedge clk);
    bus217.i_Tx_Valid = 1'b1;
    bus217.i_Tx_Byte  = 8'h37;
    @(posedge clk);
    #1 bus217.i_Tx_Valid = 1'b0;
    bus217.i_Tx_Byte = 8'hC8;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus217.o_Tx_UART !== 1'b0 && w < 50);
    check("p217_latency", 32'(w), 32'd2);
    rx = '0;
    for (int n = 0; n < 2170; n++) begin
      if (n > 0) @(negedge clk);
      if (n % 217 == 108) rx[n/217] = bus217.o_Tx_UART;
    end
    check("p217_start", 32'(rx[0]), 32'd0);
    check("p217_rx_byte", 32'(rx[8:1]), 32'h37);
    check("p217_stop", 32'(rx[9]), 32'd1);
    @(negedge clk);
    check("p217_idle_after", 32'(bus217.o_Tx_Active), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
